// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches one word per cycle from imem into a
// small FIFO and hands the oldest entry to decode; redirects flush and refetch.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t        ent [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic [31:0]   fetch_pc;
   logic          deq, enq;

   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign out_pc    = ent[rd_ptr].pc;
   assign out_instr = ent[rd_ptr].instr;
   assign deq       = out_valid & out_ready;
   // A slot freed by a dequeue is refilled in the same cycle.
   assign enq       = !redirect & ((count < CNT_FULL) | deq);

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (enq) begin
            ent[wr_ptr] <= '{pc: fetch_pc, instr: imem_rdata};
            wr_ptr      <= wr_ptr + AW'(1);
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (deq) rd_ptr <= rd_ptr + AW'(1);
         if (enq && !deq)      count <= count + (AW+1)'(1);
         else if (deq && !enq) count <= count - (AW+1)'(1);
      end
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the rv32 decode stage. Each cycle it drives a word-aligned fetch address to imem, captures the returned word with its PC into a small FIFO, and presents the oldest entry to decode through a valid/ready handshake. Branch/jump redirects from the core flush the queue and restart fetch at the new target. This decouples imem fetch from decode stalls without losing fetch bandwidth.

## Interface

- DEPTH, 4, number of queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  32  fetch address to imem (word access, zero-extended read)
- imem_rdata  in  32  imem read data for imem_addr, valid in the same cycle (combinational read)
- redirect  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced to 0)
- out_ready  in  1  decode accepts the head entry this cycle
- out_valid  out  1  head entry present
- out_instr  out  32  head instruction word
- out_pc  out  32  PC of head instruction

## Operation

- State: fetch_pc (32b), entry arrays pc[DEPTH] and instr[DEPTH], rd_ptr and wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- imem_addr = fetch_pc at all times.
- deq = out_valid & out_ready.
- enq = !redirect & (count < DEPTH | deq). On enq: entry[wr_ptr] <= {fetch_pc, imem_rdata}; wr_ptr++; fetch_pc <= fetch_pc + 4 (wraps 32'hFFFF_FFFC -> 0).
- count update: +1 on enq only, -1 on deq only, unchanged on both.
- Full queue with deq: enqueue allowed the same cycle (slot freed by dequeue is reused); count stays DEPTH.
- Full queue without deq: no enqueue; fetch_pc holds, imem_addr stable.
- redirect (highest priority): count <= 0, rd_ptr <= wr_ptr <= 0, fetch_pc <= {redirect_pc[31:2], 2'b00}. No enqueue that cycle. A simultaneous deq is honoured by the consumer as a handshake but all queue contents, including the head, are discarded.
- out_valid = (count != 0); out_instr/out_pc = entry[rd_ptr] (combinational from registers). Values when out_valid=0 are don't-care but must not contain X after reset. Reset clears the arrays to 0.
- reset overrides redirect: fetch_pc <= RESET_PC, pointers and count 0, arrays 0.

## Timing

- Reset values: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
- Fetch-to-visible latency: 1 cycle. Word fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- Redirect latency: redirect asserted in cycle N -> imem_addr=target in N+1 -> out_valid=1 with out_pc=target in N+2.
- Throughput: one enqueue and one dequeue per cycle sustained; with out_ready held high, out_pc advances by 4 every cycle.
- Entries leave strictly in fetch order; no entry duplicated or skipped except on redirect flush.
- reset held any number of cycles: outputs stay at reset values; first enqueue in the first cycle with reset=0.

## Test plan

- Reset then out_ready=1, imem returning word = address: out_valid rises 1 cycle after reset release; out_pc/out_instr = 0,4,8,12… one per cycle.
- out_ready=0 with DEPTH=4: exactly 4 enqueues, then imem_addr frozen at 0x10, count=4; raise out_ready: heads 0x0,0x4,0x8,0xC, then 0x10 with no gap.
- Full queue, out_ready pulsed one cycle: one dequeue and one enqueue same cycle; count stays 4; next head 0x4, newest entry PC 0x10.
- redirect with redirect_pc=0x0000_0103 while 3 entries held and out_ready=1: next cycle out_valid=0, imem_addr=0x100; following cycle out_pc=0x100.
- RESET_PC=32'hFFFF_FFF8, out_ready=1: out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- reset asserted mid-stream with queue partly full and redirect high: next cycle out_valid=0, imem_addr=RESET_PC; redirect ignored.
